// File: rtl/hbm_tg_pkg.sv
// Shared FSM encodings, AXI constants and pattern helper for the HBM traffic generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hbm_tg_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_ADDR = 3'd1;
    localparam logic [2:0] ST_WR_DATA = 3'd2;
    localparam logic [2:0] ST_WR_RESP = 3'd3;
    localparam logic [2:0] ST_RD_ADDR = 3'd4;
    localparam logic [2:0] ST_RD_DATA = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // One 32-bit lane of the test pattern for global beat index g.
    function automatic logic [31:0] pattern_word(input logic [31:0] seed, input logic [31:0] g);
        return seed + g;
    endfunction

endpackage

// File: rtl/hbm_tg_pattern.sv
// Expands (seed, beat index) into a full-width data word of replicated pattern lanes.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module hbm_tg_pattern
    import hbm_tg_pkg::*;
#(
    parameter int DATA_W = 256
) (
    input  logic [31:0]       seed,
    input  logic [31:0]       beat_idx,
    output logic [DATA_W-1:0] word
);

    assign word = {(DATA_W/32){pattern_word(seed, beat_idx)}};

endmodule

// File: rtl/hbm_axi_traffic_gen.sv
// AXI3 write/read-back pattern generator and checker for one HBM pseudo-channel.
// Latency: one burst outstanding; each AXI handshake advances the FSM on the next edge.
// Backpressure: valids and payloads are registered and held until ready; stalls only stretch runtime.
module hbm_axi_traffic_gen
    import hbm_tg_pkg::*;
#(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 33,
    parameter int ID_W      = 6,
    parameter int BURST_LEN = 16
) (
    input  logic                CLK100,
    input  logic                RST100_N,
    input  logic                hbm_cal_done,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base_addr,
    input  logic [15:0]         cfg_num_bursts,
    input  logic [31:0]         cfg_seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ID_W-1:0]     m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [3:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [3:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready
);

    localparam logic [ADDR_W-1:0] BEAT_BYTES  = ADDR_W'(DATA_W/8);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN*DATA_W/8);
    localparam logic [3:0]        LAST_BEAT   = 4'(BURST_LEN-1);
    localparam logic [2:0]        AXSIZE      = 3'($clog2(DATA_W/8));

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       nbursts_q;
    logic [31:0]       seed_q;
    logic [15:0]       burst_cnt;
    logic [ADDR_W-1:0] burst_addr;
    logic [3:0]        beat_cnt;
    logic [31:0]       gidx;
    logic              aw_vld, w_vld, b_rdy, ar_vld, r_rdy;

    logic [DATA_W-1:0] exp_dat;
    logic              start_acc, last_burst, at_last_beat;
    logic              b_hs, r_hs, b_err, r_err, err_evt;
    logic [ADDR_W-1:0] err_addr;
    logic [15:0]       err_cnt_nxt;
    logic              unused_ids;

    // Write data and read expectation share one generator; phases never overlap.
    hbm_tg_pattern #(.DATA_W(DATA_W)) u_pattern (
        .seed     (seed_q),
        .beat_idx (gidx),
        .word     (exp_dat)
    );

    assign start_acc    = (state == ST_IDLE) && start && hbm_cal_done;
    assign last_burst   = (burst_cnt == nbursts_q - 16'd1);
    assign at_last_beat = (beat_cnt == LAST_BEAT);

    assign b_hs  = m_bvalid && b_rdy;
    assign r_hs  = m_rvalid && r_rdy;
    assign b_err = b_hs && (m_bresp != RESP_OKAY);
    assign r_err = r_hs && ((m_rresp != RESP_OKAY) || (m_rdata != exp_dat) ||
                            (m_rlast != at_last_beat));
    assign err_evt  = b_err || r_err;
    assign err_addr = b_err ? burst_addr : burst_addr + ADDR_W'(beat_cnt) * BEAT_BYTES;
    assign err_cnt_nxt = (err_evt && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;

    assign unused_ids = ^{m_bid, m_rid};

    assign m_awid    = '0;
    assign m_awaddr  = burst_addr;
    assign m_awlen   = LAST_BEAT;
    assign m_awsize  = AXSIZE;
    assign m_awburst = BURST_INCR;
    assign m_awvalid = aw_vld;
    assign m_wdata   = exp_dat;
    assign m_wstrb   = '1;
    assign m_wlast   = w_vld && at_last_beat;
    assign m_wvalid  = w_vld;
    assign m_bready  = b_rdy;
    assign m_arid    = '0;
    assign m_araddr  = burst_addr;
    assign m_arlen   = LAST_BEAT;
    assign m_arsize  = AXSIZE;
    assign m_arburst = BURST_INCR;
    assign m_arvalid = ar_vld;
    assign m_rready  = r_rdy;

    always_ff @(posedge CLK100 or negedge RST100_N) begin
        if (!RST100_N) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (start_acc) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (err_evt) begin
            err_cnt <= err_cnt_nxt;
            // err_cnt saturates rather than wrapping, so zero means no error seen yet.
            if (err_cnt == 16'd0)
                first_err_addr <= err_addr;
        end
    end

    always_ff @(posedge CLK100 or negedge RST100_N) begin
        if (!RST100_N) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            nbursts_q  <= '0;
            seed_q     <= '0;
            burst_cnt  <= '0;
            burst_addr <= '0;
            beat_cnt   <= '0;
            gidx       <= '0;
            aw_vld     <= 1'b0;
            w_vld      <= 1'b0;
            b_rdy      <= 1'b0;
            ar_vld     <= 1'b0;
            r_rdy      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        base_q     <= cfg_base_addr;
                        nbursts_q  <= cfg_num_bursts;
                        seed_q     <= cfg_seed;
                        burst_cnt  <= '0;
                        burst_addr <= cfg_base_addr;
                        beat_cnt   <= '0;
                        gidx       <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        if (cfg_num_bursts == 16'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= 1'b1;
                        end else begin
                            state  <= ST_WR_ADDR;
                            busy   <= 1'b1;
                            aw_vld <= 1'b1;
                        end
                    end
                end
                ST_WR_ADDR: begin
                    if (aw_vld && m_awready) begin
                        aw_vld   <= 1'b0;
                        w_vld    <= 1'b1;
                        beat_cnt <= '0;
                        state    <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (w_vld && m_wready) begin
                        gidx     <= gidx + 32'd1;
                        beat_cnt <= beat_cnt + 4'd1;
                        if (at_last_beat) begin
                            w_vld <= 1'b0;
                            b_rdy <= 1'b1;
                            state <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (b_hs) begin
                        b_rdy <= 1'b0;
                        if (last_burst) begin
                            burst_cnt  <= '0;
                            burst_addr <= base_q;
                            gidx       <= '0;
                            ar_vld     <= 1'b1;
                            state      <= ST_RD_ADDR;
                        end else begin
                            burst_cnt  <= burst_cnt + 16'd1;
                            burst_addr <= burst_addr + BURST_BYTES;
                            aw_vld     <= 1'b1;
                            state      <= ST_WR_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (ar_vld && m_arready) begin
                        ar_vld   <= 1'b0;
                        r_rdy    <= 1'b1;
                        beat_cnt <= '0;
                        state    <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        gidx     <= gidx + 32'd1;
                        beat_cnt <= beat_cnt + 4'd1;
                        // The slave's rlast closes the burst; a misplaced one is counted above.
                        if (m_rlast) begin
                            r_rdy <= 1'b0;
                            if (last_burst) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                pass  <= (err_cnt_nxt == 16'd0);
                            end else begin
                                burst_cnt  <= burst_cnt + 16'd1;
                                burst_addr <= burst_addr + BURST_BYTES;
                                ar_vld     <= 1'b1;
                                state      <= ST_RD_ADDR;
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hbm_axi_traffic_gen.sv
// Bench for hbm_axi_traffic_gen: AXI slave with memory, fault injection and random stalls.
// Expected traffic and status come from a burst/beat-level model kept in queues.
// Stalls are random per cycle; held channels must keep valid and payload stable.
module tb_hbm_axi_traffic_gen;

    localparam int DATA_W    = 256;
    localparam int ADDR_W    = 33;
    localparam int ID_W      = 6;
    localparam int BURST_LEN = 16;
    localparam int BEAT_B    = DATA_W/8;
    localparam int BURST_B   = BURST_LEN*BEAT_B;

    logic                CLK100 = 1'b0;
    logic                RST100_N = 1'b0;
    logic                hbm_cal_done = 1'b0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   cfg_base_addr = '0;
    logic [15:0]         cfg_num_bursts = '0;
    logic [31:0]         cfg_seed = '0;
    logic                busy, done, pass;
    logic [15:0]         err_cnt;
    logic [ADDR_W-1:0]   first_err_addr;
    logic [ID_W-1:0]     m_awid, m_arid;
    logic [ADDR_W-1:0]   m_awaddr, m_araddr;
    logic [3:0]          m_awlen, m_arlen;
    logic [2:0]          m_awsize, m_arsize;
    logic [1:0]          m_awburst, m_arburst;
    logic                m_awvalid, m_arvalid, m_wlast, m_wvalid, m_bready, m_rready;
    logic                m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic [ID_W-1:0]     m_bid = '0, m_rid = '0;
    logic [1:0]          m_bresp = '0, m_rresp = '0;
    logic                m_bvalid = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0;
    logic [DATA_W-1:0]   m_rdata = '0;

    always #5 CLK100 = ~CLK100;

    hbm_axi_traffic_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .BURST_LEN(BURST_LEN)) dut (
        .CLK100(CLK100), .RST100_N(RST100_N), .hbm_cal_done(hbm_cal_done), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts), .cfg_seed(cfg_seed),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;

    bit bp_en = 1'b0;
    int corrupt_beat = -1;
    int bresp_err_burst = -1;
    int wr_burst = 0;
    int r_gbeat = 0;

    logic [ADDR_W-1:0] exp_aw[$];
    logic [ADDR_W-1:0] exp_ar[$];
    logic [DATA_W-1:0] exp_w[$];
    logic              exp_wl[$];
    int                exp_err_v;
    logic [ADDR_W-1:0] exp_first_v;

    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [31:0] seed, input int g);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = seed + 32'(g);
        return r;
    endfunction

    // AXI slave plus monitor: observe at negedge, drive just after posedge.
    initial begin : slave
        logic [ADDR_W-1:0] wr_addr_q[$];
        logic [ADDR_W-1:0] rd_addr_q[$];
        int                b_pend[$];
        int                w_beat, r_beat, bidx;
        logic              aw_stall, w_stall, ar_stall, r_taken, b_taken;
        logic [ADDR_W-1:0] aw_prev, ar_prev, a;
        logic [DATA_W-1:0] w_prev, d;
        logic              wl_prev;
        w_beat = 0; r_beat = 0;
        aw_stall = 0; w_stall = 0; ar_stall = 0; r_taken = 0; b_taken = 0;
        aw_prev = '0; ar_prev = '0; w_prev = '0; wl_prev = 0;
        forever begin
            @(negedge CLK100);
            r_taken = 0;
            b_taken = 0;
            if (!RST100_N) begin
                wr_addr_q.delete(); rd_addr_q.delete(); b_pend.delete();
                w_beat = 0; r_beat = 0;
                aw_stall = 0; w_stall = 0; ar_stall = 0;
            end else begin
                if (m_awvalid || m_wvalid || m_arvalid) valid_seen++;
                if (aw_stall) begin
                    chk("aw_hold_valid", m_awvalid, 1);
                    chk("aw_hold_addr", m_awaddr, aw_prev);
                end
                if (w_stall) begin
                    chk("w_hold_valid", m_wvalid, 1);
                    chk("w_hold_data", m_wdata, w_prev);
                    chk("w_hold_last", m_wlast, wl_prev);
                end
                if (ar_stall) begin
                    chk("ar_hold_valid", m_arvalid, 1);
                    chk("ar_hold_addr", m_araddr, ar_prev);
                end
                if (m_awvalid && m_awready) begin
                    chk("aw_expected", exp_aw.size() > 0, 1);
                    if (exp_aw.size() > 0) chk("awaddr", m_awaddr, exp_aw.pop_front());
                    wr_addr_q.push_back(m_awaddr);
                end
                if (m_wvalid && m_wready) begin
                    chk("w_expected", exp_w.size() > 0, 1);
                    chk("w_after_aw", wr_addr_q.size() > 0, 1);
                    if (exp_w.size() > 0) begin
                        chk("wdata", m_wdata, exp_w.pop_front());
                        chk("wlast", m_wlast, exp_wl.pop_front());
                    end
                    if (wr_addr_q.size() > 0) begin
                        a = wr_addr_q[0] + ADDR_W'(w_beat * BEAT_B);
                        mem[a] = m_wdata;
                        w_beat++;
                        if (w_beat == BURST_LEN) begin
                            w_beat = 0;
                            void'(wr_addr_q.pop_front());
                            b_pend.push_back(wr_burst);
                            wr_burst++;
                        end
                    end
                end
                if (m_bvalid && m_bready) b_taken = 1;
                if (m_arvalid && m_arready) begin
                    chk("ar_expected", exp_ar.size() > 0, 1);
                    if (exp_ar.size() > 0) chk("araddr", m_araddr, exp_ar.pop_front());
                    rd_addr_q.push_back(m_araddr);
                end
                if (m_rvalid && m_rready) begin
                    r_taken = 1;
                    r_beat++;
                    r_gbeat++;
                    if (r_beat == BURST_LEN) begin
                        r_beat = 0;
                        if (rd_addr_q.size() > 0) void'(rd_addr_q.pop_front());
                    end
                end
                aw_stall = m_awvalid && !m_awready; aw_prev = m_awaddr;
                w_stall  = m_wvalid && !m_wready;   w_prev = m_wdata; wl_prev = m_wlast;
                ar_stall = m_arvalid && !m_arready; ar_prev = m_araddr;
            end
            @(posedge CLK100);
            #1;
            if (!RST100_N) begin
                m_awready = 0; m_wready = 0; m_arready = 0;
                m_bvalid = 0; m_rvalid = 0; m_rlast = 0; m_bresp = 0;
            end else begin
                m_awready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
                m_wready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
                m_arready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!(m_bvalid && !b_taken)) begin
                    if (b_pend.size() > 0 && (!bp_en || $urandom_range(0, 1) == 1)) begin
                        bidx = b_pend.pop_front();
                        m_bvalid = 1;
                        m_bresp = (bidx == bresp_err_burst) ? 2'b10 : 2'b00;
                    end else begin
                        m_bvalid = 0;
                    end
                end
                if (!(m_rvalid && !r_taken)) begin
                    if (rd_addr_q.size() > 0 && (!bp_en || $urandom_range(0, 2) != 0)) begin
                        a = rd_addr_q[0] + ADDR_W'(r_beat * BEAT_B);
                        d = mem.exists(a) ? mem[a] : '0;
                        if (r_gbeat == corrupt_beat) d[0] = ~d[0];
                        m_rvalid = 1;
                        m_rdata = d;
                        m_rresp = 2'b00;
                        m_rlast = (r_beat == BURST_LEN-1);
                    end else begin
                        m_rvalid = 0;
                    end
                end
            end
        end
    end

    task automatic prep_run(input logic [ADDR_W-1:0] base, input int nb, input logic [31:0] seed,
                            input bit bp, input int cb, input int bb);
        logic [ADDR_W-1:0] a;
        bp_en = bp; corrupt_beat = cb; bresp_err_burst = bb;
        wr_burst = 0; r_gbeat = 0;
        exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_wl.delete();
        for (int k = 0; k < nb; k++) begin
            a = base + ADDR_W'(k * BURST_B);
            exp_aw.push_back(a);
            exp_ar.push_back(a);
            for (int b = 0; b < BURST_LEN; b++) begin
                exp_w.push_back(pat(seed, k*BURST_LEN + b));
                exp_wl.push_back(b == BURST_LEN-1);
            end
        end
        exp_err_v = 0;
        exp_first_v = '0;
        if (bb >= 0 && bb < nb) begin
            exp_err_v++;
            exp_first_v = base + ADDR_W'(bb * BURST_B);
        end
        if (cb >= 0 && cb < nb*BURST_LEN) begin
            if (exp_err_v == 0) exp_first_v = base + ADDR_W'(cb * BEAT_B);
            exp_err_v++;
        end
        cfg_base_addr = base;
        cfg_num_bursts = 16'(nb);
        cfg_seed = seed;
        hbm_cal_done = 1;
        start = 1;
        @(posedge CLK100);
        #1;
        start = 0;
        // Scramble config after launch; the run must use the latched values.
        cfg_base_addr = ADDR_W'({$urandom(), $urandom()});
        cfg_num_bursts = 16'($urandom());
        cfg_seed = $urandom();
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
    endtask

    task automatic finish_run(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge CLK100);
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pass"}, pass, (exp_err_v == 0));
        chk({tag, "_err_cnt"}, err_cnt, 16'(exp_err_v));
        chk({tag, "_first_err_addr"}, first_err_addr, exp_first_v);
        chk({tag, "_aw_drained"}, exp_aw.size(), 0);
        chk({tag, "_w_drained"}, exp_w.size(), 0);
        chk({tag, "_ar_drained"}, exp_ar.size(), 0);
        exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_wl.delete();
        repeat (3) @(posedge CLK100);
        #1;
    endtask

    task automatic run_test(input string tag, input logic [ADDR_W-1:0] base, input int nb,
                            input logic [31:0] seed, input bit bp, input int cb, input int bb);
        prep_run(base, nb, seed, bp, cb, bb);
        finish_run(tag);
    endtask

    function automatic logic [ADDR_W-1:0] rand_base();
        logic [ADDR_W-1:0] a;
        a = ADDR_W'({$urandom(), $urandom()});
        a[8:0] = '0;
        return a;
    endfunction

    initial begin : main
        int vs, cyc;
        repeat (3) @(posedge CLK100);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_first_err_addr", first_err_addr, 0);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_wlast}, 0);
        chk("rst_readies", {m_bready, m_rready}, 0);
        RST100_N = 1;
        @(posedge CLK100);
        #1;

        run_test("ideal", '0, 4, 32'hA5A5_0000, 0, -1, -1);
        run_test("corrupt17", '0, 4, 32'hA5A5_0000, 0, 17, -1);
        run_test("backpressure", rand_base(), 8, $urandom(), 1, -1, -1);
        run_test("bresp_err", rand_base(), 4, $urandom(), 0, -1, 2);

        vs = valid_seen;
        cfg_num_bursts = 0;
        hbm_cal_done = 1;
        start = 1;
        @(posedge CLK100);
        #1;
        start = 0;
        cyc = 0;
        while (!done && cyc < 2) begin
            @(negedge CLK100);
            cyc++;
        end
        chk("zero_done", done, 1);
        chk("zero_pass", pass, 1);
        chk("zero_err_cnt", err_cnt, 0);
        repeat (4) @(posedge CLK100);
        #1;
        chk("zero_no_traffic", valid_seen - vs, 0);

        vs = valid_seen;
        hbm_cal_done = 0;
        cfg_num_bursts = 4;
        start = 1;
        @(posedge CLK100);
        #1;
        start = 0;
        repeat (5) @(posedge CLK100);
        #1;
        chk("nocal_busy", busy, 0);
        chk("nocal_no_traffic", valid_seen - vs, 0);
        chk("nocal_done_held", done, 1);
        hbm_cal_done = 1;

        run_test("addr_wrap", 33'h1_FFFF_FE00, 3, $urandom(), 1, -1, -1);

        prep_run(rand_base(), 4, $urandom(), 0, -1, -1);
        cyc = 0;
        while (!(m_wvalid && exp_w.size() <= 58) && cyc < 500) begin
            @(negedge CLK100);
            cyc++;
        end
        @(posedge CLK100);
        #3;
        chk("pre_reset_in_wr_data", m_wvalid, 1);
        RST100_N = 0;
        #1;
        chk("arst_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
        chk("arst_readies", {m_bready, m_rready}, 0);
        chk("arst_status", {busy, done, pass}, 0);
        chk("arst_err_cnt", err_cnt, 0);
        repeat (2) @(posedge CLK100);
        exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_wl.delete();
        #1;
        RST100_N = 1;
        @(posedge CLK100);
        #1;
        run_test("after_reset", rand_base(), 4, $urandom(), 0, -1, -1);

        for (int i = 0; i < 3; i++)
            run_test("random", rand_base(), int'($urandom_range(1, 6)), $urandom(), 1,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hbm_axi_traffic_gen.md
Name: hbm_axi_traffic_gen

Overview:
- AXI3 write/read-back traffic generator and checker for one HBM pseudo-channel port exposed by the HBM block design.
- Sits directly upstream of the HBM stack on the CLK100 domain. Writes a deterministic pattern over a configured address range, reads it back, compares, and reports pass/fail plus error statistics.
- Used for bring-up and calibration sign-off of the HBM subsystem.

Parameters:
- DATA_W, 256, AXI data width in bits (multiple of 32).
- ADDR_W, 33, AXI byte address width.
- ID_W, 6, AXI ID width. All IDs are driven to 0.
- BURST_LEN, 16, beats per burst (1..16). AxLEN = BURST_LEN-1.

Ports:
- CLK100  in  1  sole clock, all logic rising-edge.
- RST100_N  in  1  asynchronous active-low reset.
- hbm_cal_done  in  1  HBM calibration complete. Start is ignored while low.
- start  in  1  single-cycle start pulse.
- cfg_base_addr  in  ADDR_W  first byte address. Must be aligned to BURST_LEN*DATA_W/8.
- cfg_num_bursts  in  16  number of bursts per phase.
- cfg_seed  in  32  pattern seed.
- busy / done / pass  out  1  status.
- err_cnt  out  16  saturating mismatch/response error count.
- first_err_addr  out  ADDR_W  address of the first failing beat.
- m_awid, m_awaddr, m_awlen[3:0], m_awsize[2:0], m_awburst[1:0], m_awvalid  out; m_awready  in.
- m_wdata[DATA_W], m_wstrb[DATA_W/8], m_wlast, m_wvalid  out; m_wready  in.
- m_bid, m_bresp[1:0], m_bvalid  in; m_bready  out.
- m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid  out; m_arready  in.
- m_rid, m_rdata, m_rresp[1:0], m_rlast, m_rvalid  in; m_rready  out.

Behaviour:
- Reset values: all outputs 0. pass=0, err_cnt=0, first_err_addr=0, all valids/readies 0.
- Constant AXI fields: awsize/arsize=log2(DATA_W/8), awburst/arburst=INCR, wstrb all ones, IDs 0.
- FSM states and transitions:
  - IDLE: on start && hbm_cal_done go to WR_ADDR. Clear done, err_cnt, first_err_addr, beat counter and burst counter. Set busy. If cfg_num_bursts==0, go to DONE instead with pass=1.
  - WR_ADDR -> WR_DATA -> WR_RESP. After B handshake, next burst or RD_ADDR.
  - RD_ADDR -> RD_DATA. On rlast handshake, next burst or DONE.
  - DONE: one cycle, then IDLE. done=1 and busy=0 from DONE onward. done holds until the next accepted start. pass = (err_cnt==0).
- Config is latched at start. Changes to config while busy have no effect. Start while busy is ignored.
- One outstanding burst at a time, no overlap of AW/W (AW handshake completes before first W beat).
- Valid is asserted registered and held stable until ready. Address/data must not change while valid && !ready.
- Burst k address = base + k*BURST_LEN*DATA_W/8, ADDR_W-bit wrap.
- Pattern: global beat index g (32-bit, resets to 0 at the start of each phase). Beat data = DATA_W/32 copies of (cfg_seed + g), mod 2^32. wlast on beat BURST_LEN-1 of each burst.
- m_bready is asserted only in WR_RESP. m_rready is asserted only in RD_DATA. A beat transfers on valid&&ready.
- Errors, each adding 1 to err_cnt (saturating at 0xFFFF):
  - bresp!=OKAY.
  - rresp!=OKAY.
  - rdata != expected.
  - rlast mismatch vs beat position.
- A beat carrying both a data error and a response error counts once.
- first_err_addr captures the beat byte address on the first error only. For a bresp error it captures the burst address.
- No timeout. A hang is visible as busy stuck high.

Decomposition:
- Package hbm_tg_pkg holds:
  - FSM state enum.
  - AXI constants BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - Function for pattern word generation.
- Optional sub-module hbm_tg_pattern: combinational (seed, g) -> DATA_W word, shared by the write path and the read checker.

Test Plan:
- Ideal slave (always ready, memory model), base=0x0, bursts=4, seed=0xA5A50000 -> 64 W beats at addrs 0x0,0x200,0x400,0x600; done=1, pass=1, err_cnt=0.
- Slave corrupts rdata bit 0 of global read beat 17 -> err_cnt=1, first_err_addr=base+0x220, pass=0.
- Random backpressure on awready/wready/arready/rvalid, bursts=8 -> payload/addr stable during stalls, pass=1.
- bresp=SLVERR on burst 2 -> err_cnt>=1, first_err_addr=base+0x400, run still completes with done=1.
- cfg_num_bursts=0 -> no AXI traffic, done=1 and pass=1 within 2 cycles. start with hbm_cal_done=0 -> busy stays 0.
- Assert RST100_N low mid WR_DATA -> all valids drop asynchronously, status cleared. Next start runs cleanly to pass=1.
